// File: rtl/bram_ifm_stream_rd.sv
// rtl/bram_ifm_stream_rd.sv - packed-write word store with strided, backpressured read stream
//
// Purpose:
//   Word-addressed on-chip store for input feature maps. Writes arrive PACK
//   words per beat; reads are strided bursts streamed out with a valid/ready
//   handshake. The read path is one registered memory read followed by a
//   single skid register, so there are at most two words outstanding.
//
// Ports:
//   clk, rst            sole clock (rising edge), synchronous active-high reset
//   wr_en, wr_addr      write beat strobe and word address of lane 0
//   data_in             PACK lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_err              one-cycle pulse: some lane of the previous beat was out of range
//   rd_start            start a burst (ignored while rd_busy)
//   rd_base/len/stride  first word address, word count, address increment
//   rd_busy, rd_done    burst in progress / one-cycle completion pulse
//   data_out/valid      read word stream, accepted when data_valid && data_ready
//   data_ready          consumer ready
//   rd_oob              sticky: some burst address was >= DEPTH
module bram_ifm_stream_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK       = 4,
  parameter int DEPTH      = 100352,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [PACK*DATA_WIDTH-1:0] data_in,
  output logic                       wr_err,
  input  logic                       rd_start,
  input  logic [ADDR_W-1:0]          rd_base,
  input  logic [ADDR_W-1:0]          rd_len,
  input  logic [ADDR_W-1:0]          rd_stride,
  output logic                       rd_busy,
  output logic                       rd_done,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       rd_oob
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so wr_addr+i cannot wrap back into range.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- write path
  logic [ADDR_W:0]  lane_sum [PACK];
  logic [PACK-1:0]  lane_ok;
  logic             wr_err_q;

  always_comb begin
    for (int i = 0; i < PACK; i++) begin
      lane_sum[i] = {1'b0, wr_addr} + (ADDR_W+1)'(i);
      lane_ok[i]  = (lane_sum[i] < DEPTH_X);
    end
  end

  // No reset on the array: contents survive rst, and a beat coincident with
  // rst is still written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK; i++) begin
      if (wr_en && lane_ok[i]) begin
        mem_q[lane_sum[i][IDX_W-1:0]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !(&lane_ok);
    end
  end

  // ----------------------------------------------------------------- read path
  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     stride_q, stride_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  oob_q, oob_d;
  // A = registered memory output, B = skid slot. B is always older than A.
  logic                  a_vld_q, a_vld_d;
  logic                  b_vld_q, b_vld_d;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;

  logic fire;
  logic a_keep;
  logic b_keep;
  logic issue;
  logic issue_oob;
  logic move_ab;

  assign data_valid = a_vld_q | b_vld_q;
  assign data_out   = b_vld_q ? b_data_q : a_data_q;
  assign fire       = data_valid && data_ready;
  // The consumer always takes B first when it holds a word.
  assign b_keep     = b_vld_q && !fire;
  assign a_keep     = a_vld_q && !(fire && !b_vld_q);
  assign issue_oob  = ({1'b0, addr_q} >= DEPTH_X);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    oob_d    = oob_q;
    issue    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          addr_d   = rd_base;
          stride_d = rd_stride;
          cnt_d    = rd_len;
          oob_d    = 1'b0;
          if (rd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Issue only if the landing word still fits in A/B after this cycle.
        if (!(a_keep && b_keep)) begin
          issue  = 1'b1;
          addr_d = addr_q + stride_q;
          cnt_d  = cnt_q - ADDR_W'(1);
          if (issue_oob) begin
            oob_d = 1'b1;
          end
          if (cnt_q == ADDR_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (fire && !a_keep && !b_keep) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An unconsumed A word is pushed into B to make room for the new read.
    move_ab = issue && a_keep;
    a_vld_d = issue ? 1'b1 : a_keep;
    b_vld_d = move_ab ? 1'b1 : b_keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      // Read-first: the array update from a same-cycle write lands after this read.
      if (issue) begin
        a_data_q <= issue_oob ? '0 : mem_q[addr_q[IDX_W-1:0]];
      end
      if (move_ab) begin
        b_data_q <= a_data_q;
      end
    end
  end

  assign rd_busy = (state_q != S_IDLE);
  assign rd_done = done_q;
  assign rd_oob  = oob_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_bram_ifm_stream_rd.sv
// tb/tb_bram_ifm_stream_rd.sv - self-checking bench for bram_ifm_stream_rd
//
// Purpose:
//   Drives directed and random write beats and strided bursts and compares the
//   stream against a word-array model of the store.
module tb_bram_ifm_stream_rd;

  localparam int DW    = 32;
  localparam int PACK  = 4;
  localparam int DEPTH = 64;
  localparam int AW    = 16;
  localparam int AMASK = (1 << AW) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [PACK*DW-1:0] data_in;
  logic               wr_err;
  logic               rd_start;
  logic [AW-1:0]      rd_base, rd_len, rd_stride;
  logic               rd_busy, rd_done;
  logic [DW-1:0]      data_out;
  logic               data_valid;
  logic               data_ready;
  logic               rd_oob;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem_m [DEPTH];

  bram_ifm_stream_rd #(
    .DATA_WIDTH(DW), .PACK(PACK), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .wr_err(wr_err),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_stride(rd_stride),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input int addr, input logic [PACK*DW-1:0] d, output bit err);
    err = 1'b0;
    for (int i = 0; i < PACK; i++) begin
      if (addr + i < DEPTH) mem_m[addr + i] = d[i*DW +: DW];
      else err = 1'b1;
    end
  endtask

  task automatic wr_beat(input int addr, input logic [PACK*DW-1:0] d);
    bit e;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = addr[AW-1:0]; data_in = d;
    model_write(addr, d, e);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("wr_err", wr_err, e);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_err_pulse", wr_err, 1'b0);
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  // poke: extra rd_start while busy; wr_same: write the base word in the first issue cycle.
  task automatic run_burst(input int base, input int len, input int stride, input int mode,
                           input bit poke, input bit wr_same, input int exp_first, input int exp_done);
    logic [DW-1:0] q[$];
    logic [DW-1:0] prev;
    bit            exp_oob, stalled, done, e;
    int            a, cyc, first, done_cyc, nwords, budget;
    exp_oob = 1'b0;
    for (int k = 0; k < len; k++) begin
      a = (base + k * stride) & AMASK;
      if (a < DEPTH) q.push_back(mem_m[a]);
      else begin q.push_back('0); exp_oob = 1'b1; end
    end
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = base[AW-1:0]; rd_len = len[AW-1:0]; rd_stride = stride[AW-1:0];
    @(posedge clk); #1;
    rd_start = 1'b0; rd_base = AW'($urandom); rd_len = AW'($urandom); rd_stride = AW'($urandom);
    cyc = 1; first = -1; done_cyc = -1; nwords = 0; done = 1'b0; stalled = 1'b0; prev = '0;
    budget = 8 * len + 20;
    while (!done && cyc < budget) begin
      if (wr_same && cyc == 1) begin
        wr_en = 1'b1; wr_addr = base[AW-1:0];
        data_in = {$urandom, $urandom, $urandom, $urandom};
        model_write(base, data_in, e);
      end
      if (wr_same && cyc == 2) wr_en = 1'b0;
      if (poke && cyc == 3) begin
        rd_start = 1'b1; rd_base = '0; rd_len = AW'(1); rd_stride = AW'(1);
      end
      if (poke && cyc == 4) rd_start = 1'b0;
      case (mode)
        0:       data_ready = 1'b1;
        1:       data_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: data_ready = 1'($urandom);
      endcase
      @(negedge clk);
      if (cyc == 1 && len > 0) chk("busy", rd_busy, 1'b1);
      if (stalled) begin
        chk("hold_valid", data_valid, 1'b1);
        chk("hold_data", data_out, prev);
      end
      if (data_valid) begin
        if (first < 0) first = cyc;
        if (data_ready) begin
          if (q.size() == 0) chk("extra_word", data_out, 'x);
          else chk("word", data_out, q.pop_front());
          nwords++;
        end
      end
      stalled = data_valid && !data_ready;
      prev = data_out;
      if (rd_done) begin
        done = 1'b1; done_cyc = cyc;
        chk("idle_at_done", rd_busy, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    data_ready = 1'b1;
    chk("done_seen", done, 1'b1);
    chk("word_count", nwords, len);
    chk("oob", rd_oob, exp_oob);
    if (len == 0) chk("len0_novalid", first < 0, 1'b1);
    if (exp_first >= 0) chk("first_latency", first, exp_first);
    if (exp_done >= 0) chk("done_latency", done_cyc, exp_done);
  endtask

  initial begin
    logic [PACK*DW-1:0] d;
    int n, dcnt, st;
    bit hit;
    int strides[7];
    strides = '{0, 1, 2, 3, 5, AMASK, 7};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; data_in = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_stride = '0; data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_done", rd_done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_oob", rd_oob, 1'b0);
    chk("rst_data", data_out, '0);

    // Fill with value = index.
    for (int b = 0; b < DEPTH; b += PACK) begin
      for (int i = 0; i < PACK; i++) d[i*DW +: DW] = DW'(b + i);
      wr_beat(b, d);
    end
    run_burst(1, 4, 3, 0, 0, 0, 2, 6);

    // Lanes map to consecutive words; fixed first-word and done latency.
    d = {$urandom, $urandom, $urandom, $urandom};
    wr_beat(5, d);
    run_burst(5, 4, 1, 0, 0, 0, 2, 6);

    // Backpressure with ready pattern.
    run_burst(8, 8, 1, 1, 0, 0, 2, -1);

    // Upper boundary: partial write, OOB reads return zero.
    d = {$urandom, $urandom, $urandom, $urandom};
    wr_beat(DEPTH - 2, d);
    run_burst(DEPTH - 1, 3, 1, 0, 0, 0, 2, 5);
    // Next accepted start clears the sticky flag.
    run_burst(2, 2, 1, 0, 0, 0, 2, 4);

    // Zero-length burst and rd_start while busy.
    run_burst(3, 0, 1, 0, 0, 0, -1, 1);
    run_burst(10, 6, 2, 0, 1, 0, 2, 8);

    // Same-cycle write and read of one word returns the old contents.
    run_burst(20, 1, 1, 0, 0, 1, 2, 3);
    run_burst(20, 4, 1, 0, 0, 0, 2, 6);

    // Write coincident with reset still lands; wr_err stays low.
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b1; wr_addr = AW'(DEPTH - 1);
    d = {$urandom, $urandom, $urandom, $urandom};
    data_in = d;
    model_write(DEPTH - 1, d, hit);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("rst_wr_err", wr_err, 1'b0);
    run_burst(DEPTH - 1, 1, 1, 0, 0, 0, 2, 3);

    // Reset on the third word of a len=10 burst.
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = AW'(0); rd_len = AW'(10); rd_stride = AW'(1); data_ready = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    n = 0; hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (data_valid && n == 2) begin
        hit = 1'b1;
        rst = 1'b1;
      end else begin
        if (data_valid && data_ready) n++;
        @(posedge clk); #1;
      end
    end
    chk("rst3_reached", hit, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", data_valid, 1'b0);
    chk("abort_busy", rd_busy, 1'b0);
    chk("abort_data", data_out, '0);
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    run_burst(0, 10, 1, 2, 0, 0, 2, -1);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        wr_beat($urandom_range(0, DEPTH + 2), d);
      end
      st = strides[$urandom_range(0, 6)];
      if (st == 7) st = $urandom_range(0, 40);
      run_burst($urandom_range(0, DEPTH + 6), $urandom_range(0, 10), st,
                $urandom_range(0, 2), 0, 0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_ifm_stream_rd.md
BRAM_IFM_STREAM_RD -- requirements
Module: bram_ifm_stream_rd

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning width of one stored word and of data_out.
REQ-002 SHALL provide parameter PACK, default 4, meaning words written per write beat (PACK >= 1).
REQ-003 SHALL provide parameter DEPTH, default 100352, meaning number of stored words.
REQ-004 SHALL provide parameter ADDR_W, default 32, meaning width of all address/length/stride ports.
REQ-005 One clock and one reset; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 wr_en  input  1  write beat strobe.
REQ-009 wr_addr  input  ADDR_W  word address of lane 0 of the beat.
REQ-010 data_in  input  PACK*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 wr_err  output  1  one-cycle pulse: at least one lane of previous beat out of range.
REQ-012 rd_start  input  1  start a strided read burst.
REQ-013 rd_base, rd_len, rd_stride  input  ADDR_W each  first word address, word count, address increment.
REQ-014 rd_busy  output  1  burst in progress.
REQ-015 rd_done  output  1  one-cycle pulse when burst complete.
REQ-016 data_out  output  DATA_WIDTH  read word.
REQ-017 data_valid  output  1  data_out holds a valid word.
REQ-018 data_ready  input  1  consumer accepts word when data_valid && data_ready.
REQ-019 rd_oob  output  1  sticky: some burst address was >= DEPTH; cleared on accepted rd_start.

Function
REQ-020 Write: on wr_en, lane i SHALL store to word wr_addr+i; all addresses in word units, no alignment required.
REQ-021 Lanes with wr_addr+i >= DEPTH SHALL be dropped (other lanes still written) and wr_err SHALL pulse the next cycle.
REQ-022 Read engine FSM states IDLE, RUN, FLUSH.
REQ-023 IDLE: rd_start SHALL be accepted, latching base/len/stride; rd_len != 0 -> RUN, rd_len == 0 -> rd_done pulse next cycle, stay IDLE.
REQ-024 RUN: issue word k at address rd_base + k*rd_stride (ADDR_W modulo arithmetic), k = 0..rd_len-1, via running accumulator, no multiplier.
REQ-025 Issued address >= DEPTH SHALL return all-zero data and set rd_oob; burst continues.
REQ-026 Memory read latency 1 cycle, registered output; rd_start accepted at cycle T -> first issue T+1 -> data_valid at T+2.
REQ-027 With data_ready held high, one word per cycle, no bubbles after the first.
REQ-028 Backpressure: data_out/data_valid SHALL hold while data_valid && !data_ready; no word lost, duplicated or reordered (at most 2-entry skid buffer).
REQ-029 After last issue -> FLUSH; rd_done SHALL pulse the cycle after the final word handshake; then IDLE.
REQ-030 rd_busy SHALL be 1 in RUN and FLUSH, 0 in IDLE.
REQ-031 rd_start while rd_busy SHALL be ignored.
REQ-032 Write and burst read to the same word in the same cycle: read returns old data (read-first).
REQ-033 Write beats SHALL be accepted in any FSM state.

Reset
REQ-034 rst SHALL force IDLE; rd_busy, rd_done, data_valid, wr_err, rd_oob = 0; data_out = 0; skid buffer emptied.
REQ-035 rst mid-burst SHALL abort the burst without rd_done; memory contents SHALL NOT be cleared.
REQ-036 wr_en coincident with rst SHALL still write memory; wr_err SHALL stay 0 that cycle.

Verification
REQ-037 Write beat wr_addr=5, data_in={D,C,B,A}; burst base=5,len=4,stride=1, ready=1 -> A,B,C,D on cycles T+2..T+5, rd_done at T+6.
REQ-038 Fill words 0..15 with value=index; burst base=1,len=4,stride=3 -> 1,4,7,10.
REQ-039 Burst len=8, data_ready toggled 1,0,0,1,... -> exactly 8 words in order, data_out stable while stalled.
REQ-040 Write wr_addr=DEPTH-2 -> lanes 0,1 stored, wr_err pulse; burst base=DEPTH-1,len=3,stride=1 -> last, 0, 0; rd_oob=1.
REQ-041 Burst len=0 -> rd_done one cycle later, no data_valid; rd_start during busy ignored.
REQ-042 rst asserted at 3rd word of a len=10 burst -> IDLE, data_valid=0, no rd_done; earlier written data still readable.
